// File: rtl/rc4_ctxt_feeder.sv
// Front end for rc4_decryption. It collects the 16-byte seed serially, holds the core in reset
// until the seed is complete, and queues ciphertext so nothing is lost while the core initialises.
module rc4_ctxt_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [7:0]    seed_byte,
  input  logic          seed_wr,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          init_done,
  output logic [127:0]  seed,
  output logic          core_rst_n,
  output logic [7:0]    din,
  output logic          din_valid,
  output logic          seed_loaded,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {
    LOAD_SEED = 2'd0,
    WAIT_INIT = 2'd1,
    STREAM    = 2'd2
  } state_t;

  state_t         r_state;
  logic [3:0]     r_idx;
  logic [127:0]   r_seed;
  logic           r_core_rst_n;
  logic [7:0]     r_din;
  logic           r_din_valid;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic [7:0]     r_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  // Full is judged on the registered count, so a pop never opens a slot for a push in the same cycle.
  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_push = in_valid && !w_full;
  assign w_pop  = (r_state == STREAM) && init_done && (r_count != '0);

  assign in_ready    = !w_full;
  assign seed        = r_seed;
  assign core_rst_n  = r_core_rst_n;
  assign din         = r_din;
  assign din_valid   = r_din_valid;
  assign seed_loaded = (r_state != LOAD_SEED);
  assign count       = r_count;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state      <= LOAD_SEED;
      r_idx        <= '0;
      r_seed       <= '0;
      r_core_rst_n <= 1'b0;
      r_din        <= '0;
      r_din_valid  <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else if (flush) begin
      r_state      <= LOAD_SEED;
      r_idx        <= '0;
      r_seed       <= '0;
      r_core_rst_n <= 1'b0;
      r_din        <= '0;
      r_din_valid  <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        LOAD_SEED: begin
          if (seed_wr) begin
            r_seed[{r_idx, 3'b000} +: 8] <= seed_byte;
            r_idx                        <= r_idx + 4'd1;
            if (r_idx == 4'd15) r_state <= WAIT_INIT;
          end
        end
        WAIT_INIT: if (init_done)  r_state <= STREAM;
        STREAM:    if (!init_done) r_state <= WAIT_INIT;
        default:                   r_state <= LOAD_SEED;
      endcase

      // Core reset releases one edge after the seed completes, so the core sees a stable seed.
      r_core_rst_n <= (r_state != LOAD_SEED);

      if (w_push) r_wptr <= r_wptr + AW'(1);

      if (w_pop) begin
        r_din       <= r_mem[r_rptr];
        r_din_valid <= 1'b1;
        r_rptr      <= r_rptr + AW'(1);
      end else begin
        r_din_valid <= 1'b0;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst_n) r_mem[r_wptr] <= in_byte;
  end

endmodule

// File: tb/tb_rc4_ctxt_feeder.sv
// Directed bench for rc4_ctxt_feeder: seed load, buffering across init, backpressure, gaps, flush, reset.
module tb_rc4_ctxt_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [7:0]    seed_byte;
  logic          seed_wr;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          init_done;
  logic [127:0]  seed;
  logic          core_rst_n;
  logic [7:0]    din;
  logic          din_valid;
  logic          seed_loaded;
  logic [AW:0]   count;

  int errors = 0;
  int checks = 0;

  rc4_ctxt_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .seed_byte(seed_byte), .seed_wr(seed_wr),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .init_done(init_done), .seed(seed), .core_rst_n(core_rst_n),
    .din(din), .din_valid(din_valid), .seed_loaded(seed_loaded), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [127:0] exp_seed;
  logic [7:0]   exp_q [$];
  logic [13:0]  slot_vld;
  int           nout;
  bit           acc;

  initial begin
    rst_n = 1'b1; flush = 1'b0; seed_byte = '0; seed_wr = 1'b0;
    in_byte = '0; in_valid = 1'b0; init_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    tick();

    // 1: reset state
    chk("rst_seed", seed, '0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_din_valid", din_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_seed_loaded", seed_loaded, 0);

    // 2: seed load 0x01..0x10 then an ignored 0xFF
    exp_seed = '0;
    for (int k = 0; k < 16; k++) begin
      exp_seed[k*8 +: 8] = 8'(k + 1);
      seed_byte = 8'(k + 1); seed_wr = 1'b1;
      tick();
    end
    chk("seed_loaded_16", seed_loaded, 1);
    chk("core_rst_n_same_edge", core_rst_n, 0);
    seed_byte = 8'hFF;
    tick();
    seed_wr = 1'b0;
    chk("core_rst_n_next_edge", core_rst_n, 1);
    chk("seed_value", seed, exp_seed);
    chk("seed_lo", seed[7:0], 8'h01);
    chk("seed_hi", seed[127:120], 8'h10);

    // 3: buffer 5 bytes during init, then stream them
    for (int i = 0; i < 5; i++) begin
      in_byte = 8'(8'hA0 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_count5", count, 5);
    chk("t3_no_dv", din_valid, 0);
    init_done = 1'b1;
    tick();
    chk("t3_first_edge_no_pop", din_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_dv", din_valid, 1);
      chk("t3_din", din, 8'(8'hA0 + i));
    end
    tick();
    chk("t3_dv_end", din_valid, 0);
    chk("t3_count0", count, 0);

    // 4: fill to full while core re-initialises, 17th byte waits for space
    init_done = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      in_byte = 8'(8'hB0 + i); in_valid = 1'b1;
      exp_q.push_back(8'(8'hB0 + i));
      tick();
    end
    chk("t4_count16", count, 16);
    chk("t4_in_ready0", in_ready, 0);
    in_byte = 8'hC0;
    exp_q.push_back(8'hC0);
    tick();
    chk("t4_held_count", count, 16);
    chk("t4_held_dv", din_valid, 0);
    init_done = 1'b1;
    nout = 0;
    for (int t = 0; t < 40; t++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      if (din_valid) begin
        chk("t4_din", din, (nout < exp_q.size()) ? exp_q[nout] : 8'hxx);
        nout++;
      end
    end
    chk("t4_emitted", nout, 17);
    chk("t4_count0", count, 0);

    // 5: gaps at source slots 1,5,8 appear at the matching output slots
    slot_vld = 14'b11_1110_1101_1101;
    nout = 0;
    for (int t = 0; t <= 14; t++) begin
      if (t < 14) begin
        in_valid = slot_vld[t];
        in_byte  = 8'(8'h50 + nout + (slot_vld[t] ? 0 : 0));
      end else begin
        in_valid = 1'b0;
      end
      if (t < 14 && slot_vld[t]) in_byte = 8'(8'h50 + t);
      tick();
      if (t >= 1) begin
        chk("t5_dv_slot", din_valid, slot_vld[t-1]);
        if (slot_vld[t-1]) begin
          chk("t5_din", din, 8'(8'h50 + t - 1));
          nout++;
        end
      end
    end
    chk("t5_emitted", nout, 11);

    // 6a: flush after 3 of 6 bytes emitted
    init_done = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      in_byte = 8'(8'h60 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    init_done = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_din", din, 8'(8'h60 + i));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_dv", din_valid, 0);
    chk("fl_count", count, 0);
    chk("fl_core_rst_n", core_rst_n, 0);
    chk("fl_seed", seed, '0);
    chk("fl_seed_loaded", seed_loaded, 0);
    chk("fl_in_ready", in_ready, 1);
    tick();
    chk("fl_no_leftover", din_valid, 0);

    // 6b: async reset pulse mid-stream
    for (int k = 0; k < 16; k++) begin
      seed_byte = 8'(8'h21 + k); seed_wr = 1'b1;
      tick();
    end
    seed_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_byte = 8'(8'h70 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("ar_pre_dv", din_valid, 1);
    chk("ar_pre_din", din, 8'h70);
    #2 rst_n = 1'b1;
    #1;
    chk("ar_dv", din_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_core_rst_n", core_rst_n, 0);
    chk("ar_seed", seed, '0);
    chk("ar_seed_loaded", seed_loaded, 0);
    rst_n = 1'b0;
    tick();
    chk("ar_post_dv", din_valid, 0);
    chk("ar_post_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rc4_ctxt_feeder.md
Name: rc4_ctxt_feeder

Overview:
Upstream stage of rc4_decryption: loads the 16-byte seed serially, holds the core in reset until the seed is complete, and buffers incoming ciphertext bytes in a FIFO while the core runs its key schedule. Once the core reports init_done, it streams buffered bytes to the core's din/din_valid, at most one per cycle, in arrival order. It decouples the external byte source from the core's initialization latency.

Parameters:
DEPTH, 16, ciphertext FIFO depth in bytes; must be a power of 2, minimum 2.
AW, 4, log2(DEPTH); pointer width.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of seed, FIFO and state
seed_byte  input  8  serial seed byte
seed_wr  input  1  write strobe for seed_byte
in_byte  input  8  ciphertext byte from source
in_valid  input  1  source has a byte
in_ready  output  1  FIFO can accept; equals !full
init_done  input  1  from rc4_decryption
seed  output  128  to core; byte k at bits [8k+7:8k]
core_rst_n  output  1  active-low reset to core; registered
din  output  8  ciphertext byte to core; registered
din_valid  output  1  din is a new byte this cycle; registered
seed_loaded  output  1  all 16 seed bytes written
count  output  AW+1  FIFO fill level, 0..DEPTH

Behaviour:
- Reset (rst_n=1, async): seed=0, seed index=0, seed_loaded=0, core_rst_n=0, din=0, din_valid=0, FIFO empty, count=0, in_ready=1, state=LOAD_SEED.
- States: LOAD_SEED, WAIT_INIT, STREAM. seed_loaded=1 in WAIT_INIT and STREAM.
- LOAD_SEED: each seed_wr writes seed_byte to seed byte[idx], then idx++. The 16th write (idx=15) moves to WAIT_INIT. core_rst_n is driven 0 in this state.
- Seed writes in WAIT_INIT or STREAM are ignored. seed stays stable until flush or reset.
- core_rst_n is registered (state != LOAD_SEED). It rises on the edge after the edge that took the 16th seed write.
- WAIT_INIT -> STREAM when init_done=1 is sampled.
- STREAM -> WAIT_INIT when init_done=0 is sampled (core re-init); popping stops the same edge.
- FIFO push: in_valid && in_ready, accepted in every state, including LOAD_SEED.
- in_ready = !full, computed from the registered count. A pop does not free space for a push in the same cycle, so a full FIFO shows in_ready=0 for that cycle.
- FIFO pop: occurs on any edge where state is STREAM, init_done=1 and the registered count is nonzero. Effects: din <= head byte, din_valid <= 1.
- If no pop occurs: din_valid <= 0 and din holds its previous value.
- Push into an empty FIFO is not popped the same edge. Minimum latency is 2 edges from the accepting edge to din_valid=1.
- Simultaneous push and pop: count unchanged, order preserved.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- flush (sync, highest priority over seed_wr, push and pop) restores every reset value on the next edge. Buffered bytes are discarded.
- Async reset mid-stream aborts immediately. No partial byte is emitted.

Test Plan:
1. Reset, then idle -> seed=0, core_rst_n=0, din_valid=0, count=0, in_ready=1, seed_loaded=0.
2. Seed writes 0x01..0x10, then a 17th write of 0xFF -> seed[7:0]=0x01, seed[127:120]=0x10; 0xFF ignored; seed_loaded=1; core_rst_n=1 one cycle after the 16th write.
3. Push 0xA0..0xA4 while init_done=0 -> count=5, din_valid=0. Raise init_done -> din_valid=1 for 5 consecutive cycles with din=0xA0,0xA1,0xA2,0xA3,0xA4; count returns to 0.
4. init_done=0, push 17 bytes back-to-back -> in_ready=0 after the 16th, count=16, 17th byte held by source. Raise init_done -> 17th byte accepted once space frees; all 17 emitted in order.
5. STREAM with source inserting idle cycles at byte slots 1, 5, 8 of 14 -> din_valid=0 exactly at the matching output slots; 11 bytes emitted in order.
6. Flush after 3 of 6 bytes emitted -> next edge: din_valid=0, count=0, core_rst_n=0, seed=0, state LOAD_SEED. Async rst_n pulse mid-stream -> same outputs immediately.
